divider_ctrl: RTL and testbench

//  Sequencing FSM for the restoring long-division datapath.
//  - Accepts a start/done handshake from the host.
//  - Drives datapath controls init/left/right/sub from datapath status flags.
//  - Flags divide-by-zero; supports abort.
//  - Sits beside the datapath inside divider_top: the host sees operands and results only.

---
 rtl/div_pkg.sv | 26 ++
 rtl/divider_ctrl.sv | 124 ++++++++++++
 tb/tb_divider_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: controller state encoding and default operand width.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package div_pkg;

  // Default operand width; controller and datapath must agree on it.
  localparam int DIV_SIZE = 32;

  // Controller state encoding, 3-bit binary.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_NORM  = 3'd2;
  localparam logic [2:0] ST_CMP   = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CHECK = ST_CHECK,
    NORM  = ST_NORM,
    CMP   = ST_CMP,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/divider_ctrl.sv
// Sequencing FSM for the restoring long-division datapath (start/done handshake, div-by-zero, abort).
// Latency: done in cycle 3k+5 after the start edge (k = normalisation shifts), cycle 2 for divisor 0.
// Backpressure: start is sampled only in IDLE; start while busy is ignored, abort wins over everything.
module divider_ctrl
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  output logic err_div0,
  output logic init,
  output logic left,
  output logic right,
  output logic sub,
  input  logic cnt_is_0,
  input  logic divisor_is_0,
  input  logic dvsr_le_rem,
  input  logic shifted_divisor_MSB
);

  localparam int CNT_W = $clog2(SIZE);
  // A nonzero divisor reaches its MSB after at most SIZE-1 left shifts.
  localparam logic [CNT_W:0] SHIFT_MAX = (CNT_W + 1)'(SIZE - 1);

  state_t           state_q;
  state_t           state_d;
  logic             err_q;
  logic [CNT_W:0]   shift_cnt_q;
  logic             can_left;

  // Normalisation continues while the divisor fits under the remainder and has headroom.
  // The shift-count cap only matters if the MSB flag never rises; it bounds NORM regardless.
  assign can_left = !shifted_divisor_MSB && dvsr_le_rem && (shift_cnt_q != SHIFT_MAX);

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err_div0 = err_q;

  // State register; an asserted reset drops straight to IDLE mid-operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Divide-by-zero flag: cleared when a new operation is accepted, set on the CHECK exit to DONE.
  // The left-shift counter restarts on every accepted operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q       <= 1'b0;
      shift_cnt_q <= '0;
    end else begin
      if (init) begin
        err_q       <= 1'b0;
        shift_cnt_q <= '0;
      end else begin
        if (state_q == CHECK && divisor_is_0 && !abort) begin
          err_q <= 1'b1;
        end
        if (left) begin
          shift_cnt_q <= shift_cnt_q + 1'b1;
        end
      end
    end
  end

  // Next state and datapath controls; at most one control is high because each is owned by one state.
  always_comb begin
    state_d = state_q;
    init    = 1'b0;
    left    = 1'b0;
    right   = 1'b0;
    sub     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          init    = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = divisor_is_0 ? DONE : NORM;
      end
      NORM: begin
        if (can_left) begin
          left = 1'b1;
        end else begin
          state_d = CMP;
        end
      end
      CMP: begin
        sub     = dvsr_le_rem;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (cnt_is_0) begin
          state_d = DONE;
        end else begin
          right   = 1'b1;
          state_d = CMP;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort overrides every transition and suppresses operand loading.
    if (abort) begin
      state_d = IDLE;
      init    = 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Self-checking bench for divider_ctrl with a behavioural datapath closing the loop.
// Latency: checks done cycle against 3k+5 (k from operand arithmetic) or 2 for divide-by-zero.
// Backpressure: exercises start-while-busy, start held through DONE, abort and async reset.
module tb_divider_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic abort;
  logic busy, done, err_div0, init, left, right, sub;
  logic cnt_is_0, divisor_is_0, dvsr_le_rem, shifted_divisor_MSB;

  int n_vec = 0;
  int n_err = 0;
  int onehot_viol = 0;

  divider_ctrl #(.SIZE(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .abort               (abort),
    .busy                (busy),
    .done                (done),
    .err_div0            (err_div0),
    .init                (init),
    .left                (left),
    .right               (right),
    .sub                 (sub),
    .cnt_is_0            (cnt_is_0),
    .divisor_is_0        (divisor_is_0),
    .dvsr_le_rem         (dvsr_le_rem),
    .shifted_divisor_MSB (shifted_divisor_MSB)
  );

  always #5 clk = ~clk;

  // Behavioural datapath driven by the controller's commands.
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] rem_q = '0;
  logic [31:0] dvsr_q = '0;
  logic [31:0] quo_q = '0;
  logic [5:0]  cnt_q = '0;

  always @(posedge clk) begin
    if (init) begin
      rem_q <= op_a; dvsr_q <= op_b; quo_q <= '0; cnt_q <= '0;
    end else if (left) begin
      dvsr_q <= dvsr_q << 1; cnt_q <= cnt_q + 6'd1;
    end else if (right) begin
      dvsr_q <= dvsr_q >> 1; cnt_q <= cnt_q - 6'd1; quo_q <= quo_q << 1;
    end else if (sub) begin
      rem_q <= rem_q - dvsr_q; quo_q <= quo_q | 32'd1;
    end
  end

  assign cnt_is_0            = (cnt_q == 6'd0);
  assign divisor_is_0        = (dvsr_q == 32'd0);
  assign dvsr_le_rem         = (dvsr_q <= rem_q);
  assign shifted_divisor_MSB = dvsr_q[31];

  // At most one datapath control per cycle (also covers sub/right collision).
  always @(negedge clk) begin
    if (reset && ($countones({init, left, right, sub}) > 1)) onehot_viol <= onehot_viol + 1;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Number of normalisation shifts: shifts continue while b<<j <= a and b<<j has a clear MSB.
  function automatic int exp_k(input logic [31:0] a, input logic [31:0] b);
    int clz;
    int fits;
    logic [31:0] qq;
    if (b == 32'd0 || b > a) return 0;
    clz = 0;
    for (int i = 31; i >= 0; i--) begin
      if (b[i]) break;
      clz++;
    end
    qq   = a / b;
    fits = $clog2({1'b0, qq} + 33'd1);
    return (clz < fits) ? clz : fits;
  endfunction

  // One full operation from an idle controller; caller sits 1 time unit after a rising edge.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit pulses);
    int exp_done, done_cyc, n_done, busy_low, lrs;
    exp_done = (b == 32'd0) ? 2 : 3 * exp_k(a, b) + 5;
    op_a = a; op_b = b;
    start = 1'b1;
    @(negedge clk);
    chk("init_on_start", init, 1);
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1; n_done = 0; busy_low = 0; lrs = 0;
    for (int cyc = 1; cyc < exp_done + 4; cyc++) begin
      start = (pulses && cyc < exp_done) ? ($urandom_range(0, 2) == 0) : 1'b0;
      @(negedge clk);
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          chk("err_div0_at_done", err_div0, (b == 32'd0));
        end
      end
      if (cyc < exp_done && !busy) busy_low++;
      if (left || right || sub) lrs++;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_cycle", done_cyc, exp_done);
    chk("done_count", n_done, 1);
    chk("busy_during_op", busy_low, 0);
    chk("idle_after_done", busy, 0);
    if (b == 32'd0) begin
      chk("no_ctl_on_div0", lrs, 0);
      chk("err_div0_held", err_div0, 1);
    end else begin
      chk("quotient", quo_q, a / b);
      chk("remainder", rem_q, a % b);
      chk("err_div0_clear", err_div0, 0);
    end
  endtask

  // Watch a window for stray done pulses.
  task automatic expect_quiet(input string tag, input int cycles);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done || busy) n++;
    end
    @(posedge clk); #1;
    chk(tag, n, 0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    int mode, n_done;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_div0, 0);
    chk("rst_ctl", {init, left, right, sub}, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Directed operand cases.
    run_op(32'd7, 32'd2, 1'b0);
    run_op(32'd6, 32'd3, 1'b0);
    run_op(32'd5, 32'd0, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    run_op(32'd5, 32'd9, 1'b1);

    // abort while normalising: IDLE on the next edge, no done.
    op_a = 32'd7; op_b = 32'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_norm_busy", busy, 0);
    @(posedge clk); #1;
    expect_quiet("abort_norm_quiet", 40);

    // abort together with start in IDLE: abort wins.
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_start_init", init, 0);
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    @(posedge clk); #1;

    // asynchronous reset during CMP (cycle 5 of 7/2).
    op_a = 32'd7; op_b = 32'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    #1; reset = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ctl", {init, left, right, sub}, 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    expect_quiet("reset_quiet", 40);
    run_op(32'd7, 32'd2, 1'b0);

    // start held high through DONE: re-accepted only the cycle after DONE.
    op_a = 32'd7; op_b = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    for (int i = 1; i < 11; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("held_done", done, 1);
    chk("held_init_in_done", init, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("held_idle_busy", busy, 0);
    chk("held_reaccept", init, 1);
    @(posedge clk); #1; start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    @(posedge clk); #1;
    chk("held_second_done", n_done, 1);
    chk("held_quotient", quo_q, 3);

    // Randomised operands.
    for (int t = 0; t < 24; t++) begin
      ra = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: rb = 32'd0;
        1: rb = ra;
        2: rb = ra + 32'd1;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(ra, rb, ($urandom_range(0, 1) == 1));
    end

    chk("onehot_ctl", onehot_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
